// File: rtl/bot_sysreg_if.sv
// bot_sysreg_if: bridge between the Rojobot system registers and the
// Application PicoBlaze I/O port space.
//  - Each rising edge of upd_sysregs captures a coherent snapshot of the six
//    bot registers and raises an interrupt that is held until acknowledged.
//  - A second update while the interrupt is still pending counts as an overrun.
//  - The block owns the motor-control register that feeds the bot's MotCtl_in.
// Optional build macro: BOT_IF_UPDCNT_EN adds a wrapping total-event counter
// at offset 8. When it is not defined, offset 8 reads 8'h00 and writes to it
// are ignored.
module bot_sysreg_if #(
    parameter logic [7:0] PORT_BASE = 8'h00,  // must be 16-aligned; low nibble is ignored
    parameter bit         OVR_SAT   = 1'b1    // 1: overrun count sticks at FF, 0: it wraps
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] LocX_reg,
    input  logic [7:0] LocY_reg,
    input  logic [7:0] Sensors_reg,
    input  logic [7:0] BotInfo_reg,
    input  logic [7:0] LMDist_reg,
    input  logic [7:0] RMDist_reg,
    input  logic       upd_sysregs,
    output logic [7:0] MotCtl_out,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack
);

    localparam int NUM_REGS = 6;

    localparam logic [3:0] OFF_MOTCTL = 4'h0;
    localparam logic [3:0] OFF_OVR    = 4'h6;
    localparam logic [3:0] OFF_STATUS = 4'h7;
    localparam logic [3:0] OFF_UPDCNT = 4'h8;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic                      upd_d_reg;
    logic                      upd_event;
    logic                      ovr_inc;
    logic [7:0]                ovr_cnt_reg;
    logic [7:0]                motctl_reg;
    logic [7:0]                in_port_reg;
    logic [7:0]                rd_data;
    logic                      in_block;
    logic [3:0]                offset;
    logic                      wr_en;
    logic [NUM_REGS-1:0][7:0]  live_bus;
    logic [NUM_REGS-1:0][7:0]  shadow_bus;

    // Reads never have side effects, so the read strobe carries no information.
    logic unused_read_strobe;
    assign unused_read_strobe = read_strobe;

    // Address decode: upper nibble selects the block, lower nibble the register.
    assign in_block = (port_id[7:4] == PORT_BASE[7:4]);
    assign offset   = port_id[3:0];
    assign wr_en    = write_strobe & in_block;

    // Element 0 is LocX ... element 5 is RMDist, matching read offsets 0..5.
    assign live_bus = {RMDist_reg, LMDist_reg, BotInfo_reg,
                       Sensors_reg, LocY_reg, LocX_reg};

    // Edge detector on the update flag. The delayed copy follows the flag even
    // while reset is held, so a flag that is already high when reset releases
    // is not seen as a new update.
    always_ff @(posedge clk) begin
        upd_d_reg <= upd_sysregs;
    end

    assign upd_event = upd_sysregs & ~upd_d_reg;

    // Shadow registers: all six load together on the event edge, in any state,
    // so the CPU always sees one coherent sample.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_shadow
            logic [7:0] shadow_reg;

            // Capture one live bot register on each update event.
            always_ff @(posedge clk) begin
                if (reset) begin
                    shadow_reg <= 8'h00;
                end else if (upd_event) begin
                    shadow_reg <= live_bus[gi];
                end
            end

            assign shadow_bus[gi] = shadow_reg;
        end
    endgenerate

    // Interrupt FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Interrupt FSM next state; an event arriving together with the ack is a
    // fresh request, so it keeps PEND without being counted as an overrun.
    always_comb begin
        state_next = state_reg;
        ovr_inc    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (upd_event) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                if (upd_event && !interrupt_ack) begin
                    ovr_inc = 1'b1;
                end else if (interrupt_ack && !upd_event) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign interrupt = (state_reg == PEND);

    // Overrun counter: a CPU clear takes priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_cnt_reg <= 8'h00;
        end else if (wr_en && (offset == OFF_OVR)) begin
            ovr_cnt_reg <= 8'h00;
        end else if (ovr_inc && !(OVR_SAT && (ovr_cnt_reg == 8'hFF))) begin
            ovr_cnt_reg <= ovr_cnt_reg + 8'h01;
        end
    end

    // Motor-control register written by the CPU.
    always_ff @(posedge clk) begin
        if (reset) begin
            motctl_reg <= 8'h00;
        end else if (wr_en && (offset == OFF_MOTCTL)) begin
            motctl_reg <= out_port;
        end
    end

    assign MotCtl_out = motctl_reg;

`ifdef BOT_IF_UPDCNT_EN
    logic [7:0] upd_cnt_reg;

    // Total-event counter: wraps freely, CPU clear wins over an increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            upd_cnt_reg <= 8'h00;
        end else if (wr_en && (offset == OFF_UPDCNT)) begin
            upd_cnt_reg <= 8'h00;
        end else if (upd_event) begin
            upd_cnt_reg <= upd_cnt_reg + 8'h01;
        end
    end
`endif

    // Read mux: unmapped offsets and addresses outside the block return zero.
    always_comb begin
        rd_data = 8'h00;
        if (in_block) begin
            case (offset)
                4'h0:       rd_data = shadow_bus[0];
                4'h1:       rd_data = shadow_bus[1];
                4'h2:       rd_data = shadow_bus[2];
                4'h3:       rd_data = shadow_bus[3];
                4'h4:       rd_data = shadow_bus[4];
                4'h5:       rd_data = shadow_bus[5];
                OFF_OVR:    rd_data = ovr_cnt_reg;
                OFF_STATUS: rd_data = {6'b000000, upd_d_reg, (state_reg == PEND)};
`ifdef BOT_IF_UPDCNT_EN
                OFF_UPDCNT: rd_data = upd_cnt_reg;
`endif
                default:    rd_data = 8'h00;
            endcase
        end
    end

    // Read data is registered every cycle; the CPU holds port_id for two
    // cycles, so one cycle of latency is invisible to it.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_port_reg <= 8'h00;
        end else begin
            in_port_reg <= rd_data;
        end
    end

    assign in_port = in_port_reg;

endmodule

// File: tb/tb_bot_sysreg_if.sv
// tb_bot_sysreg_if: self-checking bench for bot_sysreg_if.
// Two instances share all stimulus: one with a saturating overrun counter and
// one with a wrapping counter. Expected read data is queued when a read is
// driven and popped when the registered in_port is sampled.
module tb_bot_sysreg_if;

    localparam logic [7:0] BASE = 8'h40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] loc_x = 8'h00, loc_y = 8'h00, sensors = 8'h00;
    logic [7:0] bot_info = 8'h00, lm_dist = 8'h00, rm_dist = 8'h00;
    logic       upd = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       write_strobe = 1'b0;
    logic       read_strobe = 1'b0;
    logic       ack = 1'b0;

    logic [7:0] mot_s, mot_w, in_port_s, in_port_w;
    logic       irq_s, irq_w;

    logic [7:0] exp_s_q[$];
    logic [7:0] exp_w_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bot_sysreg_if #(.PORT_BASE(BASE), .OVR_SAT(1'b1)) u_dut_sat (
        .clk(clk), .reset(reset),
        .LocX_reg(loc_x), .LocY_reg(loc_y), .Sensors_reg(sensors),
        .BotInfo_reg(bot_info), .LMDist_reg(lm_dist), .RMDist_reg(rm_dist),
        .upd_sysregs(upd), .MotCtl_out(mot_s),
        .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe),
        .in_port(in_port_s), .interrupt(irq_s), .interrupt_ack(ack)
    );

    bot_sysreg_if #(.PORT_BASE(BASE), .OVR_SAT(1'b0)) u_dut_wrap (
        .clk(clk), .reset(reset),
        .LocX_reg(loc_x), .LocY_reg(loc_y), .Sensors_reg(sensors),
        .BotInfo_reg(bot_info), .LMDist_reg(lm_dist), .RMDist_reg(rm_dist),
        .upd_sysregs(upd), .MotCtl_out(mot_w),
        .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe),
        .in_port(in_port_w), .interrupt(irq_w), .interrupt_ack(ack)
    );

    // Drive a read and queue what each instance must return one edge later.
    task automatic rd(input logic [7:0] addr, input logic [7:0] es, input logic [7:0] ew);
        port_id     = addr;
        read_strobe = 1'b1;
        exp_s_q.push_back(es);
        exp_w_q.push_back(ew);
        @(negedge clk);
        read_strobe = 1'b0;
        $display("rd  port=%02h sat=%02h wrap=%02h", addr, in_port_s, in_port_w);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        port_id      = addr;
        out_port     = data;
        write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
        $display("wr  port=%02h data=%02h mot=%02h", addr, data, mot_s);
    endtask

    // Hold the update flag for n cycles, then one low cycle.
    task automatic pulse_upd(input int n);
        upd = 1'b1;
        repeat (n) @(negedge clk);
        upd = 1'b0;
        @(negedge clk);
        $display("upd len=%0d irq=%0b/%0b", n, irq_s, irq_w);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        $display("ack irq=%0b/%0b", irq_s, irq_w);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp += 3;
        if (in_port_s !== 8'h00) begin n_bad++; $display("FAIL reset_in_port: got %02h want 00", in_port_s); end
        if (irq_s !== 1'b0 || irq_w !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %0b/%0b want 0", irq_s, irq_w); end
        if (mot_s !== 8'h00 || mot_w !== 8'h00) begin n_bad++; $display("FAIL reset_mot: got %02h/%02h want 00", mot_s, mot_w); end
        reset = 1'b0;
        @(negedge clk);
        $display("reset released");
        n_cmp += 2;
        if (in_port_s !== 8'h00 || in_port_w !== 8'h00) begin n_bad++; $display("FAIL idle_in_port: got %02h/%02h want 00", in_port_s, in_port_w); end
        if (irq_s !== 1'b0) begin n_bad++; $display("FAIL idle_irq: got %0b want 0", irq_s); end
    endtask

    task automatic test_motctl();
        wr(BASE + 8'h00, 8'h5A);
        n_cmp++;
        if (mot_s !== 8'h5A || mot_w !== 8'h5A) begin n_bad++; $display("FAIL mot_write: got %02h/%02h want 5a", mot_s, mot_w); end
        wr(BASE + 8'h03, 8'h77);   // unmapped write offset
        wr(8'h00, 8'h11);          // offset 0 of a different block
        n_cmp++;
        if (mot_s !== 8'h5A || mot_w !== 8'h5A) begin n_bad++; $display("FAIL mot_ignore: got %02h/%02h want 5a", mot_s, mot_w); end
    endtask

    task automatic test_snapshot();
        logic [7:0] offs [10] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h49, 8'h00};
        logic [7:0] exps [10] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h00, 8'h01, 8'h00, 8'h00};
        logic [7:0] es, ew;
        loc_x = 8'h12; loc_y = 8'h34; sensors = 8'h56;
        bot_info = 8'h78; lm_dist = 8'h9A; rm_dist = 8'hBC;
        port_id = BASE + 8'h07;
        upd = 1'b1;
        @(negedge clk);
        n_cmp += 2;
        if (irq_s !== 1'b1 || irq_w !== 1'b1) begin n_bad++; $display("FAIL snap_irq_first: got %0b/%0b want 1", irq_s, irq_w); end
        if (in_port_s !== 8'h00) begin n_bad++; $display("FAIL snap_status_before: got %02h want 00", in_port_s); end
        @(negedge clk);
        n_cmp++;
        if (in_port_s !== 8'h03) begin n_bad++; $display("FAIL snap_status_held: got %02h want 03", in_port_s); end
        @(negedge clk);
        upd = 1'b0;
        @(negedge clk);
        $display("upd len=3 irq=%0b/%0b", irq_s, irq_w);
        n_cmp++;
        if (irq_s !== 1'b1) begin n_bad++; $display("FAIL snap_irq_hold: got %0b want 1", irq_s); end
        loc_x = 8'h99; loc_y = 8'h99; sensors = 8'h99;
        bot_info = 8'h99; lm_dist = 8'h99; rm_dist = 8'h99;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rd(offs[i], exps[i], exps[i]);
            es = exp_s_q.pop_front();
            ew = exp_w_q.pop_front();
            n_cmp += 2;
            if (in_port_s !== es) begin n_bad++; $display("FAIL snap_rd port=%02h: got %02h want %02h", offs[i], in_port_s, es); end
            if (in_port_w !== ew) begin n_bad++; $display("FAIL snap_rd_wrap port=%02h: got %02h want %02h", offs[i], in_port_w, ew); end
        end
    endtask

    task automatic test_ack_overrun();
        logic [7:0] offs [3] = '{8'h40, 8'h41, 8'h46};
        logic [7:0] exps [3] = '{8'hEF, 8'h01, 8'h01};
        logic [7:0] es, ew;
        pulse_ack();
        n_cmp++;
        if (irq_s !== 1'b0 || irq_w !== 1'b0) begin n_bad++; $display("FAIL ack_clear: got %0b/%0b want 0", irq_s, irq_w); end
        pulse_ack();
        n_cmp++;
        if (irq_s !== 1'b0) begin n_bad++; $display("FAIL ack_idle: got %0b want 0", irq_s); end
        loc_x = 8'hAB; loc_y = 8'hCD;
        pulse_upd(1);
        n_cmp++;
        if (irq_s !== 1'b1) begin n_bad++; $display("FAIL rearm_irq: got %0b want 1", irq_s); end
        loc_x = 8'hEF; loc_y = 8'h01;
        pulse_upd(1);
        n_cmp++;
        if (irq_s !== 1'b1 || irq_w !== 1'b1) begin n_bad++; $display("FAIL ovr_irq: got %0b/%0b want 1", irq_s, irq_w); end
        for (int i = 0; i < 3; i++) begin
            rd(offs[i], exps[i], exps[i]);
            es = exp_s_q.pop_front();
            ew = exp_w_q.pop_front();
            n_cmp += 2;
            if (in_port_s !== es) begin n_bad++; $display("FAIL ovr_rd port=%02h: got %02h want %02h", offs[i], in_port_s, es); end
            if (in_port_w !== ew) begin n_bad++; $display("FAIL ovr_rd_wrap port=%02h: got %02h want %02h", offs[i], in_port_w, ew); end
        end
    endtask

    task automatic test_ack_with_event();
        logic [7:0] es, ew;
        upd = 1'b1;
        ack = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        ack = 1'b0;
        @(negedge clk);
        $display("upd+ack irq=%0b/%0b", irq_s, irq_w);
        n_cmp++;
        if (irq_s !== 1'b1 || irq_w !== 1'b1) begin n_bad++; $display("FAIL ackevt_irq: got %0b/%0b want 1", irq_s, irq_w); end
        rd(BASE + 8'h06, 8'h01, 8'h01);
        es = exp_s_q.pop_front();
        ew = exp_w_q.pop_front();
        n_cmp += 2;
        if (in_port_s !== es) begin n_bad++; $display("FAIL ackevt_ovr: got %02h want %02h", in_port_s, es); end
        if (in_port_w !== ew) begin n_bad++; $display("FAIL ackevt_ovr_wrap: got %02h want %02h", in_port_w, ew); end
    endtask

    task automatic test_overrun_limit();
        logic [7:0] es, ew;
        wr(BASE + 8'h06, 8'h00);
        rd(BASE + 8'h06, 8'h00, 8'h00);
        es = exp_s_q.pop_front();
        ew = exp_w_q.pop_front();
        n_cmp++;
        if (in_port_s !== es || in_port_w !== ew) begin n_bad++; $display("FAIL ovr_clear0: got %02h/%02h want %02h/%02h", in_port_s, in_port_w, es, ew); end
        for (int i = 0; i < 300; i++) pulse_upd(1);
        rd(BASE + 8'h06, 8'hFF, 8'h2C);
        es = exp_s_q.pop_front();
        ew = exp_w_q.pop_front();
        n_cmp += 2;
        if (in_port_s !== es) begin n_bad++; $display("FAIL ovr_sat: got %02h want %02h", in_port_s, es); end
        if (in_port_w !== ew) begin n_bad++; $display("FAIL ovr_wrap: got %02h want %02h", in_port_w, ew); end
        // Clear and a counted overrun in the same cycle: clear wins.
        port_id      = BASE + 8'h06;
        write_strobe = 1'b1;
        upd          = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
        upd          = 1'b0;
        @(negedge clk);
        $display("wr+upd port=46 irq=%0b", irq_s);
        rd(BASE + 8'h06, 8'h00, 8'h00);
        es = exp_s_q.pop_front();
        ew = exp_w_q.pop_front();
        n_cmp++;
        if (in_port_s !== es || in_port_w !== ew) begin n_bad++; $display("FAIL ovr_clear_wins: got %02h/%02h want %02h/%02h", in_port_s, in_port_w, es, ew); end
        pulse_upd(1);
        rd(BASE + 8'h06, 8'h01, 8'h01);
        es = exp_s_q.pop_front();
        ew = exp_w_q.pop_front();
        n_cmp++;
        if (in_port_s !== es || in_port_w !== ew) begin n_bad++; $display("FAIL ovr_after_clear: got %02h/%02h want %02h/%02h", in_port_s, in_port_w, es, ew); end
    endtask

    task automatic test_reset_pend();
        logic [7:0] offs [4] = '{8'h40, 8'h41, 8'h46, 8'h47};
        logic [7:0] es, ew;
        loc_x = 8'h12; loc_y = 8'h34;
        pulse_upd(1);
        rd(BASE + 8'h00, 8'h12, 8'h12);
        es = exp_s_q.pop_front();
        ew = exp_w_q.pop_front();
        n_cmp++;
        if (in_port_s !== es || in_port_w !== ew) begin n_bad++; $display("FAIL rstp_pre: got %02h/%02h want %02h", in_port_s, in_port_w, es); end
        upd   = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (irq_s !== 1'b0 || irq_w !== 1'b0) begin n_bad++; $display("FAIL rstp_irq: got %0b/%0b want 0", irq_s, irq_w); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (irq_s !== 1'b0 || irq_w !== 1'b0) begin n_bad++; $display("FAIL rstp_held_flag: got %0b/%0b want 0", irq_s, irq_w); end
        upd = 1'b0;
        @(negedge clk);
        $display("reset in PEND irq=%0b/%0b", irq_s, irq_w);
        n_cmp += 2;
        if (irq_s !== 1'b0) begin n_bad++; $display("FAIL rstp_irq_after: got %0b want 0", irq_s); end
        if (mot_s !== 8'h00) begin n_bad++; $display("FAIL rstp_mot: got %02h want 00", mot_s); end
        for (int i = 0; i < 4; i++) begin
            rd(offs[i], 8'h00, 8'h00);
            es = exp_s_q.pop_front();
            ew = exp_w_q.pop_front();
            n_cmp += 2;
            if (in_port_s !== es) begin n_bad++; $display("FAIL rstp_rd port=%02h: got %02h want %02h", offs[i], in_port_s, es); end
            if (in_port_w !== ew) begin n_bad++; $display("FAIL rstp_rd_wrap port=%02h: got %02h want %02h", offs[i], in_port_w, ew); end
        end
    endtask

    task automatic test_updcnt();
        logic [7:0] es, ew;
        logic [7:0] exp_cnt;
`ifdef BOT_IF_UPDCNT_EN
        exp_cnt = 8'h05;
`else
        exp_cnt = 8'h00;
`endif
        wr(BASE + 8'h08, 8'h00);
        for (int i = 0; i < 5; i++) begin
            pulse_upd(1);
            pulse_ack();
        end
        rd(BASE + 8'h08, exp_cnt, exp_cnt);
        es = exp_s_q.pop_front();
        ew = exp_w_q.pop_front();
        n_cmp += 2;
        if (in_port_s !== es) begin n_bad++; $display("FAIL updcnt: got %02h want %02h", in_port_s, es); end
        if (in_port_w !== ew) begin n_bad++; $display("FAIL updcnt_wrap: got %02h want %02h", in_port_w, ew); end
        wr(BASE + 8'h08, 8'h00);
        rd(BASE + 8'h08, 8'h00, 8'h00);
        es = exp_s_q.pop_front();
        ew = exp_w_q.pop_front();
        n_cmp++;
        if (in_port_s !== es || in_port_w !== ew) begin n_bad++; $display("FAIL updcnt_clear: got %02h/%02h want 00", in_port_s, in_port_w); end
    endtask

    initial begin
        test_reset();
        test_motctl();
        test_snapshot();
        test_ack_overrun();
        test_ack_with_event();
        test_overrun_limit();
        test_reset_pend();
        test_updcnt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
